rgb_frame_parser: RTL and testbench

Byte-stream frame parser between the UART receiver and the RGB PWM controller. It consumes one received byte per `rx_valid` strobe and validates six-byte ASCII frames of the form `R<d>G<d>B<d>`, where each `<d>` is `'0'`–`'3'`. On each complete frame it publishes a registered 6-bit brightness token `{r,g,b}` with a one-cycle valid strobe. Malformed or stalled frames are discarded and counted.

---
 rtl/rgb_frame_parser_if.sv | 37 +++
 rtl/rgb_frame_parser.sv | 156 +++++++++++++++
 tb/tb_rgb_frame_parser.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_frame_parser_if.sv
// ---------------------------------------------------------------------------
// rgb_frame_parser_if
//   Groups the byte-stream input and the token/status outputs of the
//   RGB frame parser.
//
//   Signals:
//     rx_data     [7:0]  received byte, meaningful only while rx_valid = 1
//     rx_valid           one-cycle strobe per received byte
//     token       [5:0]  last accepted frame, {r[1:0], g[1:0], b[1:0]}
//     token_valid        one-cycle pulse when token is updated
//     frame_error        one-cycle pulse when a frame is abandoned
//     err_count   [7:0]  saturating count of frame_error pulses
//     busy               parser is inside a frame (state is not IDLE)
//
//   Modports:
//     master  byte source / token consumer (UART side and PWM side)
//     slave   the parser itself
// ---------------------------------------------------------------------------
interface rgb_frame_parser_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [5:0] token;
    logic       token_valid;
    logic       frame_error;
    logic [7:0] err_count;
    logic       busy;

    modport master (
        output rx_data, rx_valid,
        input  token, token_valid, frame_error, err_count, busy
    );

    modport slave (
        input  rx_data, rx_valid,
        output token, token_valid, frame_error, err_count, busy
    );
endinterface

// File: rtl/rgb_frame_parser.sv
// ---------------------------------------------------------------------------
// rgb_frame_parser
//   Validates six-byte ASCII frames "R<d>G<d>B<d>" (each <d> is '0'..'3')
//   arriving one byte per rx_valid strobe, and publishes the three 2-bit
//   digits as a registered token with a one-cycle valid pulse. Malformed
//   frames and frames that stall longer than TIMEOUT_CYCLES between bytes
//   are abandoned, flagged on frame_error and counted in err_count.
//
//   Parameters:
//     TIMEOUT_CYCLES  idle cycles allowed between bytes of a frame (>= 2)
//
//   Ports:
//     clock    system clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      slave side of rgb_frame_parser_if (byte in, token/status out)
// ---------------------------------------------------------------------------
module rgb_frame_parser #(
    parameter int TIMEOUT_CYCLES = 208320
) (
    input  logic                clock,
    input  logic                reset_n,
    rgb_frame_parser_if.slave   bus
);

    localparam int             CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CHAR_R = 8'h52;
    localparam logic [7:0] CHAR_G = 8'h47;
    localparam logic [7:0] CHAR_B = 8'h42;

    typedef enum logic [2:0] {
        IDLE,
        EXP_RD,
        EXP_G,
        EXP_GD,
        EXP_B,
        EXP_BD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] idle_cnt;
    logic [1:0]       r_stage;
    logic [1:0]       g_stage;

    // Byte classification. Digits '0'..'3' are 0x30..0x33, so the upper six
    // bits identify the class and the low two bits are the value.
    logic is_r;
    logic is_g;
    logic is_b;
    logic is_digit;

    assign is_r     = (bus.rx_data == CHAR_R);
    assign is_g     = (bus.rx_data == CHAR_G);
    assign is_b     = (bus.rx_data == CHAR_B);
    assign is_digit = (bus.rx_data[7:2] == 6'b0011_00);

    // Whether the current byte is the one the current state expects.
    // IDLE accepts everything: unknown bytes there are silently dropped.
    logic byte_ok;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        byte_ok = 1'b0;
        unique case (state)
            IDLE:                   byte_ok = 1'b1;
            EXP_RD, EXP_GD, EXP_BD: byte_ok = is_digit;
            EXP_G:                  byte_ok = is_g;
            EXP_B:                  byte_ok = is_b;
            default:                byte_ok = 1'b0;
        endcase
    end

    // A frame is abandoned either by a wrong byte or by the inter-byte
    // timeout. A byte arriving on the limit cycle wins over the timeout.
    logic timeout_hit;
    logic bad_byte;
    logic abandon;

    assign timeout_hit = (state != IDLE) && (idle_cnt == CNT_LIMIT) && !bus.rx_valid;
    assign bad_byte    = bus.rx_valid && !byte_ok;
    assign abandon     = timeout_hit || bad_byte;

    // busy is a straight decode of the state register, so it carries no
    // combinational path from the inputs.
    assign bus.busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: the staging registers are reset along with everything else; they
    // are only two bits each, and a clean reset keeps simulation X-free.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            idle_cnt        <= '0;
            r_stage         <= '0;
            g_stage         <= '0;
            bus.token       <= '0;
            bus.token_valid <= 1'b0;
            bus.frame_error <= 1'b0;
            bus.err_count   <= '0;
        end else begin
            bus.token_valid <= 1'b0;
            bus.frame_error <= 1'b0;

            // Inter-byte idle counter: only runs while inside a frame.
            if (bus.rx_valid || state == IDLE || timeout_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + CNT_W'(1);
            end

            if (abandon) begin
                bus.frame_error <= 1'b1;
                if (bus.err_count != 8'hFF) begin
                    bus.err_count <= bus.err_count + 8'd1;
                end
                // An 'R' that breaks a frame is taken as the start of the
                // next one. On a timeout rx_valid is 0, so this yields IDLE.
                state <= (bus.rx_valid && is_r) ? EXP_RD : IDLE;
            end else if (bus.rx_valid) begin
                unique case (state)
                    IDLE: begin
                        if (is_r) begin
                            state <= EXP_RD;
                        end
                    end
                    EXP_RD: begin
                        r_stage <= bus.rx_data[1:0];
                        state   <= EXP_G;
                    end
                    EXP_G: begin
                        state <= EXP_GD;
                    end
                    EXP_GD: begin
                        g_stage <= bus.rx_data[1:0];
                        state   <= EXP_B;
                    end
                    EXP_B: begin
                        state <= EXP_BD;
                    end
                    EXP_BD: begin
                        bus.token       <= {r_stage, g_stage, bus.rx_data[1:0]};
                        bus.token_valid <= 1'b1;
                        state           <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rgb_frame_parser.sv
// ---------------------------------------------------------------------------
// tb_rgb_frame_parser
//   Directed-vector bench for rgb_frame_parser with TIMEOUT_CYCLES = 8.
//   Inputs change on the falling edge; outputs are read on the falling edge
//   that follows the rising edge which consumed a byte, so after drive()
//   returns the outputs reflect the byte driven by the previous drive().
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rgb_frame_parser;

    logic clock;
    logic reset_n;
    int   vectors;
    int   miscompares;
    int   fe_seen;
    int   tv_seen;

    rgb_frame_parser_if bus ();

    rgb_frame_parser #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse monitors, sampled on the same edge the checks use.
    always @(negedge clock) begin
        if (bus.frame_error === 1'b1) fe_seen++;
        if (bus.token_valid === 1'b1) tv_seen++;
    end

    task automatic drive(input logic v, input logic [7:0] d);
        @(negedge clock);
        bus.rx_valid = v;
        bus.rx_data  = d;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            drive(1'b1, s[i]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 8'h00);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        reset_n      = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clock);
        vectors++; if (bus.token !== 6'd0) begin miscompares++; $display("FAIL reset_token: got %b expected %b", bus.token, 6'd0); end
        vectors++; if (bus.token_valid !== 1'b0) begin miscompares++; $display("FAIL reset_token_valid: got %b expected 0", bus.token_valid); end
        vectors++; if (bus.frame_error !== 1'b0) begin miscompares++; $display("FAIL reset_frame_error: got %b expected 0", bus.frame_error); end
        vectors++; if (bus.err_count !== 8'd0) begin miscompares++; $display("FAIL reset_err_count: got %0d expected 0", bus.err_count); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        reset_n = 1'b1;
        idle(2);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_nominal();
        int tv0;
        tv0 = tv_seen;
        drive(1'b1, 8'h52);
        drive(1'b1, 8'h33);
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL nominal_busy_mid: got %b expected 1", bus.busy); end
        drive(1'b1, 8'h47);
        drive(1'b1, 8'h31);
        drive(1'b1, 8'h42);
        drive(1'b1, 8'h32);
        vectors++; if (bus.token_valid !== 1'b0) begin miscompares++; $display("FAIL nominal_tv_early: got %b expected 0", bus.token_valid); end
        drive(1'b0, 8'h00);
        vectors++; if (bus.token_valid !== 1'b1) begin miscompares++; $display("FAIL nominal_tv: got %b expected 1", bus.token_valid); end
        vectors++; if (bus.token !== 6'b11_01_10) begin miscompares++; $display("FAIL nominal_token: got %b expected %b", bus.token, 6'b11_01_10); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL nominal_busy_end: got %b expected 0", bus.busy); end
        drive(1'b0, 8'h00);
        vectors++; if (bus.token_valid !== 1'b0) begin miscompares++; $display("FAIL nominal_tv_width: got %b expected 0", bus.token_valid); end
        vectors++; if (bus.err_count !== 8'd0) begin miscompares++; $display("FAIL nominal_err_count: got %0d expected 0", bus.err_count); end
        #1;
        vectors++; if (tv_seen - tv0 !== 1) begin miscompares++; $display("FAIL nominal_tv_pulses: got %0d expected 1", tv_seen - tv0); end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_bad_digit_resync();
        drive(1'b1, 8'h52);
        drive(1'b1, 8'h34);
        drive(1'b0, 8'h00);
        vectors++; if (bus.frame_error !== 1'b1) begin miscompares++; $display("FAIL bad_digit_fe: got %b expected 1", bus.frame_error); end
        vectors++; if (bus.err_count !== 8'd1) begin miscompares++; $display("FAIL bad_digit_err_count: got %0d expected 1", bus.err_count); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL bad_digit_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.token !== 6'b11_01_10) begin miscompares++; $display("FAIL bad_digit_token_kept: got %b expected %b", bus.token, 6'b11_01_10); end
        idle(1);
        // R2GR1G1B1: the second 'R' breaks the frame and starts a new one.
        send_str("R2GR");
        drive(1'b1, "1");
        vectors++; if (bus.frame_error !== 1'b1) begin miscompares++; $display("FAIL resync_fe: got %b expected 1", bus.frame_error); end
        vectors++; if (bus.err_count !== 8'd2) begin miscompares++; $display("FAIL resync_err_count: got %0d expected 2", bus.err_count); end
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL resync_busy: got %b expected 1", bus.busy); end
        send_str("G1B1");
        drive(1'b0, 8'h00);
        vectors++; if (bus.token_valid !== 1'b1) begin miscompares++; $display("FAIL resync_tv: got %b expected 1", bus.token_valid); end
        vectors++; if (bus.token !== 6'b01_01_01) begin miscompares++; $display("FAIL resync_token: got %b expected %b", bus.token, 6'b01_01_01); end
        vectors++; if (bus.err_count !== 8'd2) begin miscompares++; $display("FAIL resync_err_final: got %0d expected 2", bus.err_count); end
        idle(1);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_back_to_back();
        drive(1'b1, 8'h0D);
        drive(1'b1, 8'h0A);
        drive(1'b0, 8'h00);
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL noise_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.frame_error !== 1'b0) begin miscompares++; $display("FAIL noise_fe: got %b expected 0", bus.frame_error); end
        send_str("R1G2B3");
        drive(1'b1, "R");
        vectors++; if (bus.token_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_tv1: got %b expected 1", bus.token_valid); end
        vectors++; if (bus.token !== 6'b01_10_11) begin miscompares++; $display("FAIL b2b_token1: got %b expected %b", bus.token, 6'b01_10_11); end
        send_str("0G0B0");
        drive(1'b0, 8'h00);
        vectors++; if (bus.token_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_tv2: got %b expected 1", bus.token_valid); end
        vectors++; if (bus.token !== 6'b00_00_00) begin miscompares++; $display("FAIL b2b_token2: got %b expected %b", bus.token, 6'b00_00_00); end
        vectors++; if (bus.err_count !== 8'd2) begin miscompares++; $display("FAIL b2b_err_count: got %0d expected 2", bus.err_count); end
        idle(1);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_timeout();
        int fe0;
        #1 fe0 = fe_seen;
        // Counter reads k-1 at the k-th idle cycle; it holds 7 during the
        // 8th, so the error is visible after the 9th.
        send_str("R2");
        idle(8);
        vectors++; if (bus.frame_error !== 1'b0) begin miscompares++; $display("FAIL timeout_early_fe: got %b expected 0", bus.frame_error); end
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL timeout_early_busy: got %b expected 1", bus.busy); end
        idle(1);
        vectors++; if (bus.frame_error !== 1'b1) begin miscompares++; $display("FAIL timeout_fe: got %b expected 1", bus.frame_error); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL timeout_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.err_count !== 8'd3) begin miscompares++; $display("FAIL timeout_err_count: got %0d expected 3", bus.err_count); end
        idle(2);
        // 'G' lands on the limit cycle: byte wins, frame continues.
        send_str("R2");
        idle(7);
        drive(1'b1, "G");
        drive(1'b0, 8'h00);
        vectors++; if (bus.frame_error !== 1'b0) begin miscompares++; $display("FAIL limit_byte_fe: got %b expected 0", bus.frame_error); end
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL limit_byte_busy: got %b expected 1", bus.busy); end
        send_str("1B0");
        drive(1'b0, 8'h00);
        vectors++; if (bus.token_valid !== 1'b1) begin miscompares++; $display("FAIL limit_byte_tv: got %b expected 1", bus.token_valid); end
        vectors++; if (bus.token !== 6'b10_01_00) begin miscompares++; $display("FAIL limit_byte_token: got %b expected %b", bus.token, 6'b10_01_00); end
        idle(1);
        #1;
        vectors++; if (fe_seen - fe0 !== 1) begin miscompares++; $display("FAIL timeout_fe_pulses: got %0d expected 1", fe_seen - fe0); end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_saturation();
        int fe0;
        #1 fe0 = fe_seen;
        for (int i = 0; i < 300; i++) begin
            send_str("RX");
        end
        idle(2);
        vectors++; if (bus.err_count !== 8'd255) begin miscompares++; $display("FAIL sat_err_count: got %0d expected 255", bus.err_count); end
        #1;
        vectors++; if (fe_seen - fe0 !== 300) begin miscompares++; $display("FAIL sat_fe_pulses: got %0d expected 300", fe_seen - fe0); end
        // One more error at saturation still pulses and stays at 255.
        send_str("RX");
        drive(1'b0, 8'h00);
        vectors++; if (bus.frame_error !== 1'b1) begin miscompares++; $display("FAIL sat_fe_at_max: got %b expected 1", bus.frame_error); end
        vectors++; if (bus.err_count !== 8'd255) begin miscompares++; $display("FAIL sat_hold: got %0d expected 255", bus.err_count); end
        idle(1);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset_mid_frame();
        int tv0;
        int fe0;
        send_str("R3G");
        @(negedge clock);
        bus.rx_valid = 1'b0;
        reset_n      = 1'b0;
        #1;
        vectors++; if (bus.err_count !== 8'd0) begin miscompares++; $display("FAIL async_reset_err_count: got %0d expected 0", bus.err_count); end
        vectors++; if (bus.token !== 6'd0) begin miscompares++; $display("FAIL async_reset_token: got %b expected 0", bus.token); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL async_reset_busy: got %b expected 0", bus.busy); end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        #1 tv0 = tv_seen;
        fe0 = fe_seen;
        send_str("B1");
        idle(2);
        vectors++; if (bus.token !== 6'd0) begin miscompares++; $display("FAIL post_reset_token: got %b expected 0", bus.token); end
        vectors++; if (bus.err_count !== 8'd0) begin miscompares++; $display("FAIL post_reset_err_count: got %0d expected 0", bus.err_count); end
        #1;
        vectors++; if (tv_seen - tv0 !== 0) begin miscompares++; $display("FAIL post_reset_tv_pulses: got %0d expected 0", tv_seen - tv0); end
        vectors++; if (fe_seen - fe0 !== 0) begin miscompares++; $display("FAIL post_reset_fe_pulses: got %0d expected 0", fe_seen - fe0); end
        send_str("R2G3B1");
        drive(1'b0, 8'h00);
        vectors++; if (bus.token_valid !== 1'b1) begin miscompares++; $display("FAIL post_reset_frame_tv: got %b expected 1", bus.token_valid); end
        vectors++; if (bus.token !== 6'b10_11_01) begin miscompares++; $display("FAIL post_reset_frame_token: got %b expected %b", bus.token, 6'b10_11_01); end
        idle(1);
    endtask

    // -----------------------------------------------------------------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        fe_seen     = 0;
        tv_seen     = 0;
        test_reset();
        test_nominal();
        test_bad_digit_resync();
        test_back_to_back();
        test_timeout();
        test_saturation();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
